twos_to_signmag_serial: RTL and testbench

Bit-serial converter that decodes an 8-bit two's-complement word back into sign-magnitude form. It is the inverse-direction companion of the combinational two's-complement negator. Words are accepted over a valid/ready input handshake and processed LSB-first, one bit per clock. Each result is presented over a valid/ready output handshake. It sits between arithmetic datapaths that produce two's-complement values and display or serial-output logic that needs sign plus magnitude.

---
 rtl/twos_to_signmag_serial.sv | 137 +++++++++++++
 tb/tb_twos_to_signmag_serial.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/twos_to_signmag_serial.sv
// Bit-serial two's-complement to sign-magnitude converter.
// A word is accepted over valid/ready and walked LSB first, one bit per clock.
// Negative words use the "copy through the first one, invert above it" rule.
// The most-negative word has no magnitude in WIDTH-1 bits. It is flagged and
// saturated to the all-ones magnitude.
module twos_to_signmag_serial #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_sign,
  output logic [WIDTH-2:0] out_mag,
  output logic             out_ovf
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state_r;
  state_t           state_s;
  logic [WIDTH-1:0] shreg_r;
  logic [WIDTH-2:0] result_r;    // decoded bits so far, newest at the top
  logic [WIDTH-1:0] result_s;    // result including the bit decoded this cycle
  logic [CW-1:0]    cnt_r;
  logic             sign_r;
  logic             seen_r;
  logic             seen_s;
  logic             bit_s;

  // One decoded output bit. For a negative word the bits above the first one are inverted.
  function automatic logic decode_bit(input logic sign, input logic seen, input logic b);
    if (sign && seen) begin
      return ~b;
    end else begin
      return b;
    end
  endfunction

  // Next-state selection and the per-bit decode datapath.
  always_comb begin
    state_s  = state_r;
    bit_s    = decode_bit(sign_r, seen_r, shreg_r[0]);
    seen_s   = seen_r | (sign_r & shreg_r[0]);
    result_s = {bit_s, result_r};
    case (state_r)
      IDLE: begin
        if (in_valid) begin
          state_s = SHIFT;
        end else begin
          state_s = IDLE;
        end
      end
      SHIFT: begin
        if (cnt_r == LAST) begin
          state_s = DONE;
        end else begin
          state_s = SHIFT;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_s = IDLE;
        end else begin
          state_s = DONE;
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // State register, datapath registers and registered handshake and result outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r   <= IDLE;
      shreg_r   <= {WIDTH{1'b0}};
      result_r  <= {(WIDTH-1){1'b0}};
      cnt_r     <= {CW{1'b0}};
      sign_r    <= 1'b0;
      seen_r    <= 1'b0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      out_sign  <= 1'b0;
      out_mag   <= {(WIDTH-1){1'b0}};
      out_ovf   <= 1'b0;
    end else begin
      state_r   <= state_s;
      in_ready  <= (state_s == IDLE);
      out_valid <= (state_s == DONE);
      case (state_r)
        IDLE: begin
          if (in_valid) begin
            shreg_r  <= in_data;
            sign_r   <= in_data[WIDTH-1];
            seen_r   <= 1'b0;
            cnt_r    <= {CW{1'b0}};
            result_r <= {(WIDTH-1){1'b0}};
          end
        end
        SHIFT: begin
          shreg_r  <= shreg_r >> 1;
          seen_r   <= seen_s;
          result_r <= result_s[WIDTH-1:1];
          cnt_r    <= cnt_r + CW'(1);
          if (cnt_r == LAST) begin
            // A set result MSB on a negative word only happens for 100...0.
            out_ovf  <= sign_r & result_s[WIDTH-1];
            out_sign <= sign_r;
            if (sign_r && result_s[WIDTH-1]) begin
              out_mag <= {(WIDTH-1){1'b1}};
            end else begin
              out_mag <= result_s[WIDTH-2:0];
            end
          end
        end
        DONE: begin
          // Results are held until the consumer takes them.
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_twos_to_signmag_serial.sv
// Self-checking bench for twos_to_signmag_serial (WIDTH = 8).
// Directed vectors use hand-computed literals. An arithmetic reference model
// and queue check every valid output cycle.
module tb_twos_to_signmag_serial;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_data;
  logic       out_valid;
  logic       out_ready;
  logic       out_sign;
  logic [6:0] out_mag;
  logic       out_ovf;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  logic [8:0] exp_q[$];

  twos_to_signmag_serial #(.WIDTH(8)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_sign(out_sign), .out_mag(out_mag), .out_ovf(out_ovf)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Reference model: sign and magnitude from plain signed arithmetic, returned as {sign, mag, ovf}.
  function automatic logic [8:0] model(input logic [7:0] d);
    int v;
    v = int'($signed(d));
    if (v == -128) return {1'b1, 7'h7F, 1'b1};
    if (v < 0) return {1'b1, 7'(-v), 1'b0};
    return {1'b0, 7'(v), 1'b0};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Scoreboard: accepted words queue model results; each valid output cycle is compared.
  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
    end else begin
      if (out_valid) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL spurious_out_valid actual sign=%0b mag=%0h ovf=%0b expected no result", out_sign, out_mag, out_ovf);
        end else begin
          if ({out_sign, out_mag, out_ovf} !== exp_q[0]) begin
            errors++;
            $display("FAIL model_compare actual=%0h expected=%0h", {out_sign, out_mag, out_ovf}, exp_q[0]);
          end
          if (out_ready) void'(exp_q.pop_front());
        end
      end
      if (in_valid && in_ready) exp_q.push_back(model(in_data));
    end
  end

  // Wait for out_valid, returning the number of edges waited (bounded).
  task automatic wait_valid(output int n, input logic watch_ready);
    n = 0;
    while (!out_valid && n < 30) begin
      if (watch_ready && in_ready) chk("in_ready_during_conv", in_ready, 1'b0);
      @(posedge clk); #1;
      n++;
    end
  endtask

  // One full conversion with out_ready held high.
  task automatic xfer(input string name, input logic [7:0] d, input logic es,
                      input logic [6:0] em, input logic eo);
    int n;
    n = 0;
    while (!in_ready && n < 20) begin @(posedge clk); #1; n++; end
    chk({name, "_in_ready_idle"}, in_ready, 1'b1);
    in_data = d; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    wait_valid(n, 1'b1);
    chk({name, "_latency"}, n, 8);
    chk({name, "_sign"}, out_sign, es);
    chk({name, "_mag"}, out_mag, em);
    chk({name, "_ovf"}, out_ovf, eo);
    @(posedge clk); #1;
    chk({name, "_valid_drop"}, out_valid, 1'b0);
    chk({name, "_ready_back"}, in_ready, 1'b1);
  endtask

  initial begin
    int n;
    int c0;
    int c1;
    int seen_valid;
    rst = 1'b1; in_valid = 1'b0; in_data = 8'h00; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", in_ready, 1'b1);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_outs", {out_sign, out_mag, out_ovf}, 9'h000);
    rst = 1'b0;
    @(posedge clk); #1;

    xfer("p5",   8'h05, 1'b0, 7'h05, 1'b0);
    xfer("m5",   8'hFB, 1'b1, 7'h05, 1'b0);
    xfer("m1",   8'hFF, 1'b1, 7'h01, 1'b0);
    xfer("zero", 8'h00, 1'b0, 7'h00, 1'b0);
    xfer("max",  8'h7F, 1'b0, 7'h7F, 1'b0);
    xfer("mneg", 8'h80, 1'b1, 7'h7F, 1'b1);
    xfer("m127", 8'h81, 1'b1, 7'h7F, 1'b0);

    // Backpressure on -10 with an in_valid pulse offered while results are held.
    out_ready = 1'b0;
    in_data = 8'hF6; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    wait_valid(n, 1'b1);
    chk("bp_latency", n, 8);
    for (int i = 0; i < 5; i++) begin
      in_data = 8'h11; in_valid = 1'b1;
      chk("bp_valid_held", out_valid, 1'b1);
      chk("bp_sign", out_sign, 1'b1);
      chk("bp_mag", out_mag, 7'h0A);
      chk("bp_in_ready", in_ready, 1'b0);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp_valid_drop", out_valid, 1'b0);
    chk("bp_ready_back", in_ready, 1'b1);
    seen_valid = 0;
    repeat (12) begin
      @(posedge clk); #1;
      if (out_valid) seen_valid++;
    end
    chk("bp_no_extra_result", seen_valid, 0);

    // Back-to-back with in_valid held high.
    in_data = 8'h80; in_valid = 1'b1;
    @(posedge clk); #1;
    c0 = cyc;
    in_data = 8'h01;
    n = 0;
    seen_valid = 0;
    while (!in_ready && n < 30) begin
      if (out_valid) begin
        seen_valid++;
        chk("b2b_first", {out_sign, out_mag, out_ovf}, {1'b1, 7'h7F, 1'b1});
      end
      @(posedge clk); #1;
      n++;
    end
    @(posedge clk); #1;
    c1 = cyc;
    in_valid = 1'b0;
    chk("b2b_spacing", c1 - c0, 10);
    chk("b2b_first_count", seen_valid, 1);
    wait_valid(n, 1'b1);
    chk("b2b_second", {out_sign, out_mag, out_ovf}, {1'b0, 7'h01, 1'b0});
    @(posedge clk); #1;

    // Abort mid-conversion with reset at count 3.
    in_data = 8'hC0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("abort_in_ready", in_ready, 1'b1);
    chk("abort_out_valid", out_valid, 1'b0);
    chk("abort_outs", {out_sign, out_mag, out_ovf}, 9'h000);
    seen_valid = 0;
    repeat (12) begin
      @(posedge clk); #1;
      if (out_valid) seen_valid++;
    end
    chk("abort_no_result", seen_valid, 0);
    xfer("after_abort", 8'h02, 1'b0, 7'h02, 1'b0);

    chk("queue_drained", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Watchdog against a hung run.
  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "timeout");
  end

endmodule
